ucs_sequencer: RTL and testbench
================================

# ucs_sequencer

Control FSM that drives the unsat-clause selector through one solve: problem load, then repeated select/present/flip iterations until the unsat buffer is empty (SAT), a flip budget expires (TIMEOUT), or the selector overflows (ERROR). It owns the selector's `setup`, `request_i` and `write_disable_i` inputs. It hands each selected clause to the downstream literal-pick/flip unit over a valid/ready handshake.

## Interface
- `BUFFER_DEPTH`, 2048, unsat buffer depth; `CW = $clog2(BUFFER_DEPTH)`.
- `NSAT`, 3, literals per clause.
- `LITERAL_ADDRESS_WIDTH`, 12, bits per literal; `CLW = NSAT*LITERAL_ADDRESS_WIDTH`.
- `SELECT_LATENCY`, 4, cycles from the request pulse to valid selector data.
- `FLIP_WIDTH`, 32, flip counter width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start_i` in 1: begin load; honoured in IDLE/SAT/TIMEOUT/ERROR only.
- `abort_i` in 1: return to IDLE from any state.
- `load_done_i` in 1: host has finished writing clauses.
- `max_flips_i` in FLIP_WIDTH: flip budget, sampled on `start_i`.
- `buffer_count_i` in CW: selector unsat count.
- `fifo_empty_i` in 1: clause-update FIFO empty.
- `ucb_overflow_i` in 1: selector overflow flag.
- `selected_i` in CLW: selector output data.
- `setup_o` out 1: selector setup mode.
- `request_o` out 1: one-cycle selection pulse.
- `write_disable_o` out 1: freezes buffer writes.
- `clause_valid_o` out 1, `clause_o` out CLW, `clause_ready_i` in 1: downstream handshake.
- `flip_done_i` in 1: downstream finished the flip and queued its updates.
- `flip_count_o` out FLIP_WIDTH: flips performed this solve.
- `busy_o`, `sat_o`, `timeout_o`, `error_o` out 1 each: status.

## Operation
- States: IDLE, LOAD, SETTLE, CHECK, REQ, WAIT, PRESENT, FLIP, SAT, TIMEOUT, ERROR.
- IDLE: `write_disable_o`=1.
  - `start_i` → LOAD.
  - Entering LOAD clears `flip_count_o` and the sticky status flags, and latches `max_flips_i`.
- LOAD: `setup_o`=1, `write_disable_o`=0. `load_done_i` → SETTLE.
- SETTLE: wait until `fifo_empty_i`=1 for one sampled cycle, so that `buffer_count_i` is stable. Then → CHECK.
- CHECK: priority order, first match wins:
  1. `buffer_count_i`==0 → SAT.
  2. `flip_count_o`==latched max → TIMEOUT.
  3. Otherwise → REQ.
- REQ: `request_o`=1 for exactly this cycle. → WAIT, and load the latency counter with SELECT_LATENCY-1.
- WAIT: count down to 0.
  - On the edge where the counter is 0, register `selected_i` into `clause_o`.
  - Same edge: → PRESENT.
- PRESENT: `clause_valid_o`=1 with `clause_o` held stable. The handshake completes on the edge with `clause_ready_i`=1; then → FLIP.
- FLIP: on `flip_done_i`, increment `flip_count_o` (saturating at all-ones), then → SETTLE.
- SAT / TIMEOUT / ERROR:
  - Terminal; the matching status output is 1 and `write_disable_o`=1.
  - `start_i` restarts at LOAD.
- `ucb_overflow_i`=1 in any state except IDLE → ERROR on the next edge. This has priority over every transition except `abort_i`.
- `abort_i` has highest priority: → IDLE next edge.
  - Status flags clear.
  - `flip_count_o` holds its value.
  - An in-flight request is discarded; the latency counter resets.
- `busy_o`=1 in LOAD through FLIP.
- `max_flips_i`=0 → TIMEOUT straight after the first CHECK, unless the count is 0 (SAT wins).

## Timing
- Reset values:
  - State is IDLE.
  - Outputs: `write_disable_o`=1; every other output is 0, including `clause_o`.
  - The latched max is 0.
- All outputs are registered, or are decoded from the registered state only. There is no combinational path from any input to any output.
- Request-to-capture: `request_o` is high in cycle T, and `selected_i` is sampled at the end of cycle T+SELECT_LATENCY.
- Best-case loop: SETTLE(1) + CHECK(1) + REQ(1) + WAIT(SELECT_LATENCY) + PRESENT(1) + FLIP(1) = 9 cycles per flip at the default latency.
- `clause_valid_o` must not drop and `clause_o` must not change until the handshake completes.
- `request_o` is never asserted twice without an intervening capture or abort.

## Structure
- Package `ucs_pkg` holds:
  - the state enum `ucs_state_t`;
  - the `CLW` and `CW` derivation functions;
  - the default SELECT_LATENCY.
- One sub-module, `ucs_latency_timer`: a loadable down-counter with `load`, `value` and `zero` ports, reused by WAIT.
- Everything else stays in a single FSM always block plus the datapath registers.

## Test plan
- **Normal SAT exit:** load 3 clauses, then drive `buffer_count_i` 3→2→1→0 after each `flip_done_i` → 3 handshakes, `flip_count_o`=3, `sat_o`=1, `busy_o`=0.
- **Budget exhaustion:** `max_flips_i`=2, `buffer_count_i` held at 5 → exactly 2 `request_o` pulses, `timeout_o`=1, `flip_count_o`=2.
- **Latency/capture:** `request_o` at cycle 10; `selected_i`=0xABC123456 only in cycle 14 and garbage otherwise → `clause_o`=0xABC123456.
- **Back-pressure:** `clause_ready_i` low for 20 cycles → `clause_valid_o` and `clause_o` stable throughout, and no new `request_o`.
- **Overflow mid-WAIT:** assert `ucb_overflow_i` 2 cycles after `request_o` → ERROR next edge, `error_o`=1, `clause_valid_o` never asserted.
- **Reset and abort:**
  - Async `reset` pulse mid-PRESENT → outputs at their reset values immediately, without waiting for a clock edge.
  - `abort_i` in FLIP → IDLE with `flip_count_o` held.

Source files
------------

// File: rtl/ucs_pkg.sv
// ucs_pkg: shared state encoding and width helpers for the unsat-clause sequencer
package ucs_pkg;

    localparam int SELECT_LATENCY_DEFAULT = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_REQ,
        ST_WAIT,
        ST_PRESENT,
        ST_FLIP,
        ST_SAT,
        ST_TIMEOUT,
        ST_ERROR
    } ucs_state_t;

    function automatic int clw(input int nsat, input int law);
        return nsat * law;
    endfunction

    function automatic int cw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ucs_latency_timer.sv
// ucs_latency_timer: loadable down-counter that parks at zero
module ucs_latency_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (load)
            r_count <= value;
        else if (!zero)
            r_count <= r_count - 1'b1;
    end

    assign zero = r_count == '0;

endmodule

// File: rtl/ucs_sequencer.sv
// ucs_sequencer: drives the unsat-clause selector through load and select/present/flip iterations
module ucs_sequencer
    import ucs_pkg::*;
#(
    parameter int BUFFER_DEPTH          = 2048,
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int SELECT_LATENCY        = SELECT_LATENCY_DEFAULT,
    parameter int FLIP_WIDTH            = 32,
    localparam int CW                   = cw(BUFFER_DEPTH),
    localparam int CLW                  = clw(NSAT, LITERAL_ADDRESS_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  load_done_i,
    input  logic [FLIP_WIDTH-1:0] max_flips_i,
    input  logic [CW-1:0]         buffer_count_i,
    input  logic                  fifo_empty_i,
    input  logic                  ucb_overflow_i,
    input  logic [CLW-1:0]        selected_i,
    output logic                  setup_o,
    output logic                  request_o,
    output logic                  write_disable_o,
    output logic                  clause_valid_o,
    output logic [CLW-1:0]        clause_o,
    input  logic                  clause_ready_i,
    input  logic                  flip_done_i,
    output logic [FLIP_WIDTH-1:0] flip_count_o,
    output logic                  busy_o,
    output logic                  sat_o,
    output logic                  timeout_o,
    output logic                  error_o
);

    localparam int TW = $clog2(SELECT_LATENCY + 1);

    ucs_state_t            r_state;
    ucs_state_t            w_next;
    logic [FLIP_WIDTH-1:0] r_flip_count;
    logic [FLIP_WIDTH-1:0] r_max;
    logic [CLW-1:0]        r_clause;
    logic                  w_zero;

    ucs_latency_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (abort_i),
        .load  (r_state == ST_REQ),
        .value (TW'(SELECT_LATENCY - 1)),
        .zero  (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_SAT, ST_TIMEOUT, ST_ERROR: w_next = start_i ? ST_LOAD : r_state;
            ST_LOAD:    w_next = load_done_i ? ST_SETTLE : ST_LOAD;
            ST_SETTLE:  w_next = fifo_empty_i ? ST_CHECK : ST_SETTLE;
            ST_CHECK:   w_next = buffer_count_i == '0 ? ST_SAT :
                                 r_flip_count == r_max ? ST_TIMEOUT : ST_REQ;
            ST_REQ:     w_next = ST_WAIT;
            ST_WAIT:    w_next = w_zero ? ST_PRESENT : ST_WAIT;
            ST_PRESENT: w_next = clause_ready_i ? ST_FLIP : ST_PRESENT;
            ST_FLIP:    w_next = flip_done_i ? ST_SETTLE : ST_FLIP;
            default:    w_next = ST_IDLE;
        endcase
        if (ucb_overflow_i && r_state != ST_IDLE)
            w_next = ST_ERROR;
        if (abort_i)
            w_next = ST_IDLE;
    end

    // Datapath updates key off the resolved next state so abort/overflow suppress them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flip_count <= '0;
            r_max        <= '0;
            r_clause     <= '0;
        end else begin
            if (w_next == ST_LOAD && r_state != ST_LOAD) begin
                r_flip_count <= '0;
                r_max        <= max_flips_i;
            end else if (r_state == ST_FLIP && w_next == ST_SETTLE && !(&r_flip_count))
                r_flip_count <= r_flip_count + 1'b1;
            if (r_state == ST_WAIT && w_next == ST_PRESENT)
                r_clause <= selected_i;
        end
    end

    always_comb begin
        setup_o         = r_state == ST_LOAD;
        request_o       = r_state == ST_REQ;
        clause_valid_o  = r_state == ST_PRESENT;
        write_disable_o = r_state inside {ST_IDLE, ST_SAT, ST_TIMEOUT, ST_ERROR};
        busy_o          = r_state inside {ST_LOAD, ST_SETTLE, ST_CHECK, ST_REQ,
                                          ST_WAIT, ST_PRESENT, ST_FLIP};
        sat_o           = r_state == ST_SAT;
        timeout_o       = r_state == ST_TIMEOUT;
        error_o         = r_state == ST_ERROR;
    end

    assign clause_o     = r_clause;
    assign flip_count_o = r_flip_count;

endmodule

// File: tb/tb_ucs_sequencer.sv
// tb_ucs_sequencer: scenario tasks plus a selector/consumer model feeding a clause scoreboard
module tb_ucs_sequencer;
    import ucs_pkg::*;

    localparam int CW = 11, CLW = 36, FW = 32, LAT = SELECT_LATENCY_DEFAULT;

    logic clk = 1'b0, reset = 1'b1;
    logic start_i = 0, abort_i = 0, load_done_i = 0, fifo_empty_i = 1, ucb_overflow_i = 0;
    logic clause_ready_i = 0, flip_done_i = 0;
    logic [FW-1:0] max_flips_i = '0;
    logic [CW-1:0] buffer_count_i = '0;
    logic [CLW-1:0] selected_i = '0, clause_o;
    logic setup_o, request_o, write_disable_o, clause_valid_o, busy_o, sat_o, timeout_o, error_o;
    logic [FW-1:0] flip_count_o;

    int passed = 0, total = 0, req_count = 0, hs_count = 0, cyc = 0, cd = -1;
    int req_cyc[$];
    logic [CLW-1:0] exp_q[$];
    logic [CLW-1:0] next_clause = 36'h111111111, pend = '0;
    bit ready_en = 0, auto_dec = 0, hs_prev = 0;

    ucs_sequencer dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i), .load_done_i(load_done_i),
        .max_flips_i(max_flips_i), .buffer_count_i(buffer_count_i), .fifo_empty_i(fifo_empty_i),
        .ucb_overflow_i(ucb_overflow_i), .selected_i(selected_i), .setup_o(setup_o),
        .request_o(request_o), .write_disable_o(write_disable_o), .clause_valid_o(clause_valid_o),
        .clause_o(clause_o), .clause_ready_i(clause_ready_i), .flip_done_i(flip_done_i),
        .flip_count_o(flip_count_o), .busy_o(busy_o), .sat_o(sat_o), .timeout_o(timeout_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Selector returns the clause only in cycle T+LAT; consumer pops the scoreboard on each handshake
    task automatic model();
        logic [CLW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                cd = -1; hs_prev = 0; flip_done_i = 0; clause_ready_i = 0;
            end else begin
                if (request_o) begin
                    total++;
                    if (cd >= 0) $display("FAIL request_overlap: request_o=1 with capture pending cd=%0d, want none", cd);
                    else passed++;
                    cd = LAT; pend = next_clause; exp_q.push_back(next_clause);
                    next_clause += 36'h010203041; req_count++; req_cyc.push_back(cyc);
                end else if (cd > 0) cd--;
                selected_i = (cd == 0) ? pend : pend ^ {4'($urandom), $urandom | 32'h1};
                if (cd == 0) cd = -1;
                flip_done_i = hs_prev;
                if (hs_prev && auto_dec && buffer_count_i != '0) buffer_count_i = buffer_count_i - 1'b1;
                hs_prev = 0;
                clause_ready_i = ready_en;
                if (clause_valid_o && clause_ready_i) begin
                    total++;
                    if (exp_q.size() == 0) $display("FAIL scoreboard: got clause %h, want nothing pending", clause_o);
                    else begin
                        e = exp_q.pop_front();
                        if (clause_o !== e) $display("FAIL scoreboard: got clause %h want %h", clause_o, e);
                        else passed++;
                    end
                    hs_prev = 1; hs_count++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1; start_i = 0; abort_i = 0; load_done_i = 0; ucb_overflow_i = 0;
        tick();
        reset = 0; exp_q.delete(); cd = -1;
        tick();
    endtask

    task automatic start_solve(input logic [FW-1:0] mf, input logic [CW-1:0] bc);
        max_flips_i = mf; buffer_count_i = bc; start_i = 1;
        tick();
        start_i = 0; load_done_i = 1;
        tick();
        load_done_i = 0;
    endtask

    task automatic test_reset();
        tick(2);
        total++; if (write_disable_o !== 1'b1) $display("FAIL rst_wd: got %b want 1", write_disable_o); else passed++;
        total++; if ({setup_o, request_o, clause_valid_o, busy_o, sat_o, timeout_o, error_o} !== 7'b0)
            $display("FAIL rst_flags: got %b want 0000000", {setup_o, request_o, clause_valid_o, busy_o, sat_o, timeout_o, error_o}); else passed++;
        total++; if (clause_o !== '0) $display("FAIL rst_clause: got %h want 0", clause_o); else passed++;
        total++; if (flip_count_o !== '0) $display("FAIL rst_flips: got %0d want 0", flip_count_o); else passed++;
        reset = 0;
        tick();
        total++; if ({busy_o, write_disable_o} !== 2'b01) $display("FAIL idle_hold: got %b want 01", {busy_o, write_disable_o}); else passed++;
    endtask

    task automatic test_sat();
        int h0 = hs_count, r0 = req_cyc.size();
        auto_dec = 1; ready_en = 1;
        start_solve(10, 3);
        for (int i = 0; i < 200 && sat_o !== 1'b1; i++) tick();
        total++; if (sat_o !== 1'b1) $display("FAIL sat_flag: got %b want 1", sat_o); else passed++;
        total++; if (hs_count - h0 != 3) $display("FAIL sat_handshakes: got %0d want 3", hs_count - h0); else passed++;
        total++; if (flip_count_o !== 32'd3) $display("FAIL sat_flips: got %0d want 3", flip_count_o); else passed++;
        total++; if ({busy_o, write_disable_o} !== 2'b01) $display("FAIL sat_busy_wd: got %b want 01", {busy_o, write_disable_o}); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL sat_queue: got %0d left want 0", exp_q.size()); else passed++;
        total++;
        if (req_cyc.size() < r0 + 3 || req_cyc[r0+2] - req_cyc[r0] != 18)
            $display("FAIL loop_period: got %0d reqs want 3 spaced 9 cycles apart", req_cyc.size() - r0);
        else passed++;
        auto_dec = 0;
    endtask

    task automatic test_timeout();
        int r0;
        do_reset();
        r0 = req_count;
        start_solve(2, 5);
        for (int i = 0; i < 200 && timeout_o !== 1'b1; i++) tick();
        total++; if (timeout_o !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout_o); else passed++;
        total++; if (req_count - r0 != 2) $display("FAIL to_requests: got %0d want 2", req_count - r0); else passed++;
        total++; if (flip_count_o !== 32'd2) $display("FAIL to_flips: got %0d want 2", flip_count_o); else passed++;
        total++; if ({sat_o, busy_o} !== 2'b00) $display("FAIL to_other: got %b want 00", {sat_o, busy_o}); else passed++;
        r0 = req_count;
        start_solve(0, 5);
        for (int i = 0; i < 20 && timeout_o !== 1'b1; i++) tick();
        total++; if (timeout_o !== 1'b1) $display("FAIL zero_budget: got %b want 1", timeout_o); else passed++;
        total++; if (req_count != r0) $display("FAIL zero_budget_req: got %0d want 0", req_count - r0); else passed++;
        total++; if (flip_count_o !== '0) $display("FAIL zero_budget_flips: got %0d want 0", flip_count_o); else passed++;
        start_solve(0, 0);
        for (int i = 0; i < 20 && sat_o !== 1'b1; i++) tick();
        total++; if ({sat_o, timeout_o} !== 2'b10) $display("FAIL sat_beats_budget: got %b want 10", {sat_o, timeout_o}); else passed++;
    endtask

    task automatic test_latency();
        int r0;
        do_reset();
        ready_en = 0; next_clause = 36'hABC123456; r0 = req_cyc.size();
        start_solve(5, 5);
        for (int i = 0; i < 50 && clause_valid_o !== 1'b1; i++) tick();
        total++; if (clause_valid_o !== 1'b1) $display("FAIL lat_valid: got %b want 1", clause_valid_o); else passed++;
        total++; if (clause_o !== 36'hABC123456) $display("FAIL lat_capture: got %h want abc123456", clause_o); else passed++;
        total++;
        if (req_cyc.size() <= r0 || cyc - req_cyc[r0] != LAT + 1)
            $display("FAIL lat_cycles: got %0d want %0d", req_cyc.size() > r0 ? cyc - req_cyc[r0] : -1, LAT + 1);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [CLW-1:0] snap = clause_o;
        int r0 = req_count, bad = 0, h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clause_valid_o !== 1'b1 || clause_o !== snap || request_o !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else passed++;
        total++; if (req_count != r0) $display("FAIL bp_no_request: got %0d want 0", req_count - r0); else passed++;
        h0 = hs_count; ready_en = 1;
        for (int i = 0; i < 10 && hs_count == h0; i++) tick();
        total++; if (hs_count != h0 + 1) $display("FAIL bp_release: got %0d handshakes want 1", hs_count - h0); else passed++;
    endtask

    task automatic test_overflow();
        int bad = 0;
        do_reset();
        ready_en = 1;
        start_solve(5, 5);
        for (int i = 0; i < 20 && request_o !== 1'b1; i++) tick();
        total++; if (request_o !== 1'b1) $display("FAIL ovf_request: got %b want 1", request_o); else passed++;
        tick(2);
        ucb_overflow_i = 1;
        tick();
        ucb_overflow_i = 0;
        total++; if ({error_o, busy_o, write_disable_o} !== 3'b101) $display("FAIL ovf_error: got %b want 101", {error_o, busy_o, write_disable_o}); else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clause_valid_o !== 1'b0 || error_o !== 1'b1) bad++;
        end
        total++; if (bad != 0) $display("FAIL ovf_no_valid: got %0d bad cycles want 0", bad); else passed++;
        exp_q.delete(); cd = -1;
    endtask

    task automatic test_async_reset();
        do_reset();
        ready_en = 0;
        start_solve(5, 5);
        for (int i = 0; i < 50 && clause_valid_o !== 1'b1; i++) tick();
        total++; if (clause_valid_o !== 1'b1) $display("FAIL ar_present: got %b want 1", clause_valid_o); else passed++;
        #2 reset = 1;
        #1;
        total++; if ({clause_valid_o, busy_o, write_disable_o} !== 3'b001) $display("FAIL ar_flags: got %b want 001", {clause_valid_o, busy_o, write_disable_o}); else passed++;
        total++; if (clause_o !== '0) $display("FAIL ar_clause: got %h want 0", clause_o); else passed++;
        tick();
        reset = 0; exp_q.delete(); cd = -1;
        tick();
    endtask

    task automatic test_abort();
        int h0 = hs_count;
        ready_en = 1; auto_dec = 0;
        start_solve(5, 5);
        for (int i = 0; i < 100 && hs_count < h0 + 2; i++) tick();
        total++; if (hs_count != h0 + 2) $display("FAIL ab_handshakes: got %0d want 2", hs_count - h0); else passed++;
        tick();
        abort_i = 1;
        tick();
        abort_i = 0;
        total++; if ({busy_o, write_disable_o} !== 2'b01) $display("FAIL ab_idle: got %b want 01", {busy_o, write_disable_o}); else passed++;
        total++; if (flip_count_o !== 32'd1) $display("FAIL ab_flips_held: got %0d want 1", flip_count_o); else passed++;
        total++; if ({sat_o, timeout_o, error_o} !== 3'b000) $display("FAIL ab_status: got %b want 000", {sat_o, timeout_o, error_o}); else passed++;
        start_i = 1;
        tick();
        start_i = 0;
        total++; if ({setup_o, busy_o} !== 2'b11 || flip_count_o !== '0)
            $display("FAIL restart_load: got setup/busy %b flips %0d want 11 and 0", {setup_o, busy_o}, flip_count_o); else passed++;
        abort_i = 1;
        tick();
        abort_i = 0;
        total++; if ({setup_o, busy_o} !== 2'b00) $display("FAIL ab_load: got %b want 00", {setup_o, busy_o}); else passed++;
    endtask

    initial begin
        fork
            model();
        join_none
        test_reset();
        test_sat();
        test_timeout();
        test_latency();
        test_backpressure();
        test_overflow();
        test_async_reset();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
